// File: rtl/rom_twiddle_fetch_ctrl_if.sv
// rtl/rom_twiddle_fetch_ctrl_if.sv - ROM read bus and twiddle output stream bundle
interface rom_twiddle_fetch_ctrl_if #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 64,
  parameter int NUM_ROM = 4
);
  logic              rom_valid;
  logic [ADDR_W-1:0] rom_addr_col1;
  logic [ADDR_W-1:0] rom_addr_col2;
  logic [DATA_W-1:0] rom_data_col1 [NUM_ROM-1:0];
  logic [DATA_W-1:0] rom_data_col2 [NUM_ROM-1:0];
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] tw_col1 [NUM_ROM-1:0];
  logic [DATA_W-1:0] tw_col2 [NUM_ROM-1:0];

  modport master (
    output rom_valid, rom_addr_col1, rom_addr_col2,
    input  rom_data_col1, rom_data_col2,
    output out_valid, tw_col1, tw_col2,
    input  out_ready
  );

  modport slave (
    input  rom_valid, rom_addr_col1, rom_addr_col2,
    output rom_data_col1, rom_data_col2,
    input  out_valid, tw_col1, tw_col2,
    output out_ready
  );
endinterface

// File: rtl/rom_twiddle_fetch_ctrl.sv
// rtl/rom_twiddle_fetch_ctrl.sv - twiddle ROM read sequencer with credit-limited output FIFO
module rom_twiddle_fetch_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 64,
  parameter int NUM_ROM    = 4,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         cfg_len,
  rom_twiddle_fetch_ctrl_if.master bus,
  output logic                    busy,
  output logic                    done
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + ROM_LAT + 2) + 1;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   len_q, k_q;
  logic [ADDR_W:0]   issue_k, issue_len;
  logic [ROM_LAT-1:0] vsr_q;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, inflight, occ;
  logic              issue, push, pop;

  logic [DATA_W-1:0] mem1 [FIFO_DEPTH-1:0][NUM_ROM-1:0];
  logic [DATA_W-1:0] mem2 [FIFO_DEPTH-1:0][NUM_ROM-1:0];

  // The read strobe itself plus every shift stage is a slot already promised to the FIFO
  always_comb begin
    inflight = CW'(bus.rom_valid);
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + CW'(vsr_q[i]);
    end
  end

  assign occ           = count + inflight;
  assign push          = vsr_q[ROM_LAT-1];
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign busy          = (state == S_ISSUE) || (state == S_DRAIN);
  assign done          = (state == S_DONE);

  // Next-state and issue decision; the first read goes out on the start edge itself
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    issue_k   = k_q;
    issue_len = len_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          issue_len = cfg_len;
          issue_k   = '0;
          if (cfg_len != '0) begin
            issue    = 1'b1;
            state_nx = (cfg_len == LEN_ONE) ? S_DRAIN : S_ISSUE;
          end else begin
            // Zero-length runs still pass through DRAIN so done trails start like any run
            state_nx = S_DRAIN;
          end
        end
      end
      S_ISSUE: begin
        if (occ < CW'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (k_q == len_q - LEN_ONE) begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final entry is popped so done lands on the following cycle
        if (inflight == '0 && (count == '0 || (count == CW'(1) && pop))) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, address counters, registered ROM strobe/addresses and in-flight shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      len_q             <= '0;
      k_q               <= '0;
      vsr_q             <= '0;
      bus.rom_valid     <= 1'b0;
      bus.rom_addr_col1 <= '0;
      bus.rom_addr_col2 <= '0;
    end else begin
      state         <= state_nx;
      bus.rom_valid <= issue;
      vsr_q         <= ROM_LAT'({vsr_q, bus.rom_valid});
      if (state == S_IDLE && start) begin
        len_q <= issue_len;
      end
      if (issue) begin
        k_q               <= issue_k + LEN_ONE;
        bus.rom_addr_col1 <= issue_k[ADDR_W-1:0];
        bus.rom_addr_col2 <= ADDR_W'(issue_len - LEN_ONE - issue_k);
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage captures both columns when the in-flight tap says ROM data is valid
  always_ff @(posedge clk) begin
    if (push) begin
      for (int b = 0; b < NUM_ROM; b++) begin
        mem1[wr_ptr][b] <= bus.rom_data_col1[b];
        mem2[wr_ptr][b] <= bus.rom_data_col2[b];
      end
    end
  end

  // Head presentation, forced to zero while empty so reset leaves every output low
  always_comb begin
    for (int b = 0; b < NUM_ROM; b++) begin
      bus.tw_col1[b] = bus.out_valid ? mem1[rd_ptr][b] : '0;
      bus.tw_col2[b] = bus.out_valid ? mem2[rd_ptr][b] : '0;
    end
  end
endmodule

// File: tb/tb_rom_twiddle_fetch_ctrl.sv
// tb/tb_rom_twiddle_fetch_ctrl.sv - directed vector bench for the twiddle fetch controller
module tb_rom_twiddle_fetch_ctrl;
  logic clk, rst_na, rst_nb;
  logic start_a, start_b, busy_a, busy_b, done_a, done_b;
  logic [11:0] cfg_len_a, cfg_len_b;
  int n_vec = 0;
  int n_err = 0;

  rom_twiddle_fetch_ctrl_if #(.ADDR_W(11), .DATA_W(64), .NUM_ROM(4)) bus_a ();
  rom_twiddle_fetch_ctrl_if #(.ADDR_W(11), .DATA_W(64), .NUM_ROM(4)) bus_b ();

  rom_twiddle_fetch_ctrl #(.ADDR_W(11), .DATA_W(64), .NUM_ROM(4), .ROM_LAT(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_na), .start(start_a), .cfg_len(cfg_len_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a));

  rom_twiddle_fetch_ctrl #(.ADDR_W(11), .DATA_W(64), .NUM_ROM(4), .ROM_LAT(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .cfg_len(cfg_len_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int col, input logic [10:0] addr, input int b);
    return {8'(col), 8'(b), 16'hA55A, 21'd0, addr};
  endfunction

  // ROM models: A has latency 1, B latency 3; data is junk outside the valid window
  logic        pv_a;
  logic [10:0] pa1_a, pa2_a;
  logic [2:0]  pv_b;
  logic [10:0] pa1_b [0:2];
  logic [10:0] pa2_b [0:2];
  int occ_a = 0, occ_b = 0, ovf_a = 0, ovf_b = 0, rv_cnt_a = 0;
  int iss_b = 0, addr_err_b = 0;
  logic [10:0] last_a2_b = '1;

  always @(posedge clk or negedge rst_na) begin
    if (!rst_na) begin
      pv_a  <= 1'b0;
      occ_a <= 0;
    end else begin
      pv_a  <= bus_a.rom_valid;
      pa1_a <= bus_a.rom_addr_col1;
      pa2_a <= bus_a.rom_addr_col2;
      occ_a <= occ_a + int'(pv_a) - int'(bus_a.out_valid && bus_a.out_ready);
      if (bus_a.rom_valid) rv_cnt_a <= rv_cnt_a + 1;
    end
  end

  always @(posedge clk or negedge rst_nb) begin
    if (!rst_nb) begin
      pv_b  <= '0;
      occ_b <= 0;
      iss_b <= 0;
    end else begin
      pv_b     <= {pv_b[1:0], bus_b.rom_valid};
      pa1_b[0] <= bus_b.rom_addr_col1;
      pa2_b[0] <= bus_b.rom_addr_col2;
      pa1_b[1] <= pa1_b[0];
      pa2_b[1] <= pa2_b[0];
      pa1_b[2] <= pa1_b[1];
      pa2_b[2] <= pa2_b[1];
      occ_b <= occ_b + int'(pv_b[2]) - int'(bus_b.out_valid && bus_b.out_ready);
      if (bus_b.rom_valid) begin
        iss_b     <= iss_b + 1;
        last_a2_b <= bus_b.rom_addr_col2;
        if (bus_b.rom_addr_col1 != 11'(iss_b) || bus_b.rom_addr_col2 != 11'(2047 - iss_b))
          addr_err_b <= addr_err_b + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (occ_a > 4) ovf_a <= ovf_a + 1;
    if (occ_b > 4) ovf_b <= ovf_b + 1;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bus_a.rom_data_col1[b] = pv_a ? word(1, pa1_a, b) : 64'hDEAD_BEEF_DEAD_BEEF;
      bus_a.rom_data_col2[b] = pv_a ? word(2, pa2_a, b) : 64'hDEAD_BEEF_DEAD_BEEF;
      bus_b.rom_data_col1[b] = pv_b[2] ? word(1, pa1_b[2], b) : 64'hDEAD_BEEF_DEAD_BEEF;
      bus_b.rom_data_col2[b] = pv_b[2] ? word(2, pa2_b[2], b) : 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_head_a(input string nm, input int k, input int len);
    int bad = -1;
    logic [63:0] e1, e2;
    for (int b = 0; b < 4; b++) begin
      if (bus_a.tw_col1[b] !== word(1, 11'(k), b) || bus_a.tw_col2[b] !== word(2, 11'(len - 1 - k), b))
        bad = b;
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      e1 = word(1, 11'(k), bad);
      e2 = word(2, 11'(len - 1 - k), bad);
      $display("FAIL %s entry %0d bank %0d: got %h/%h expected %h/%h", nm, k, bad,
               bus_a.tw_col1[bad], bus_a.tw_col2[bad], e1, e2);
    end
  endtask

  task automatic check_head_b(input int k);
    int bad = -1;
    logic [63:0] e1, e2;
    for (int b = 0; b < 4; b++) begin
      if (bus_b.tw_col1[b] !== word(1, 11'(k), b) || bus_b.tw_col2[b] !== word(2, 11'(2047 - k), b))
        bad = b;
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      e1 = word(1, 11'(k), bad);
      e2 = word(2, 11'(2047 - k), bad);
      $display("FAIL rand entry %0d bank %0d: got %h/%h expected %h/%h", k, bad,
               bus_b.tw_col1[bad], bus_b.tw_col2[bad], e1, e2);
    end
  endtask

  // One run on A: ready held low for 'hold' cycles, optional ignored restart in cycle 3
  task automatic run_a(input int len, input int hold, input int restart_len, input string nm);
    int got = 0, dones = 0, post = -1, rv0;
    rv0 = rv_cnt_a;
    start_a   = 1'b1;
    cfg_len_a = 12'(len);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bus_a.out_ready = (cyc >= hold);
      @(negedge clk);
      if (hold > 0 && cyc == hold - 2) begin
        check({nm, " issues under stall"}, 64'(rv_cnt_a - rv0), 64'd4);
        check({nm, " rom_valid idle"}, 64'(bus_a.rom_valid), 64'd0);
        check({nm, " fifo full"}, 64'(bus_a.out_valid), 64'd1);
        check({nm, " model occupancy"}, 64'(occ_a), 64'd4);
        check_head_a({nm, " held head"}, 0, len);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        check_head_a(nm, got, len);
        got++;
      end
      if (done_a) begin
        dones++;
        if (post < 0) post = 3;
      end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      if (restart_len > 0 && cyc == 2) begin
        start_a   = 1'b1;
        cfg_len_a = 12'(restart_len);
      end
      if (post == 0) break;
      if (post > 0) post--;
    end
    start_a = 1'b0;
    check({nm, " entries"}, 64'(got), 64'(len));
    check({nm, " done pulses"}, 64'(dones), 64'd1);
  endtask

  typedef struct {
    int st, len, rdy, rv, a1, a2, ov, hk, elen, busy, done;
  } vec_t;
  vec_t vt [13];

  int got_b, dones_b;

  initial begin
    vt[0]  = '{1, 4, 1, 0, 0, 0, 0, 0, 4, 0, 0};
    vt[1]  = '{0, 4, 1, 1, 0, 3, 0, 0, 4, 1, 0};
    vt[2]  = '{0, 4, 1, 1, 1, 2, 0, 0, 4, 1, 0};
    vt[3]  = '{0, 4, 1, 1, 2, 1, 1, 0, 4, 1, 0};
    vt[4]  = '{0, 4, 1, 1, 3, 0, 1, 1, 4, 1, 0};
    vt[5]  = '{0, 4, 1, 0, 3, 0, 1, 2, 4, 1, 0};
    vt[6]  = '{0, 4, 1, 0, 3, 0, 1, 3, 4, 1, 0};
    vt[7]  = '{0, 4, 1, 0, 3, 0, 0, 0, 4, 0, 1};
    vt[8]  = '{0, 4, 1, 0, 3, 0, 0, 0, 4, 0, 0};
    vt[9]  = '{1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 0};
    vt[11] = '{0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1};
    vt[12] = '{0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0};

    rst_na = 1'b0; rst_nb = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    cfg_len_a = '0; cfg_len_b = '0;
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rom_valid", 64'(bus_a.rom_valid), 64'd0);
    check("reset addr1", 64'(bus_a.rom_addr_col1), 64'd0);
    check("reset addr2", 64'(bus_a.rom_addr_col2), 64'd0);
    check("reset out_valid", 64'(bus_a.out_valid), 64'd0);
    check("reset tw_col1", bus_a.tw_col1[0], 64'd0);
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset done", 64'(done_a), 64'd0);
    @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      start_a         = vt[i].st[0];
      cfg_len_a       = 12'(vt[i].len);
      bus_a.out_ready = vt[i].rdy[0];
      @(negedge clk);
      check($sformatf("vec%0d rom_valid", i), 64'(bus_a.rom_valid), 64'(vt[i].rv));
      check($sformatf("vec%0d addr1", i), 64'(bus_a.rom_addr_col1), 64'(vt[i].a1));
      check($sformatf("vec%0d addr2", i), 64'(bus_a.rom_addr_col2), 64'(vt[i].a2));
      check($sformatf("vec%0d out_valid", i), 64'(bus_a.out_valid), 64'(vt[i].ov));
      check($sformatf("vec%0d busy", i), 64'(busy_a), 64'(vt[i].busy));
      check($sformatf("vec%0d done", i), 64'(done_a), 64'(vt[i].done));
      if (vt[i].ov != 0) check_head_a($sformatf("vec%0d head", i), vt[i].hk, vt[i].elen);
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;

    run_a(16, 20, 0, "backpressure");
    run_a(8, 0, 7, "restart ignored");

    bus_a.out_ready = 1'b0;
    start_a   = 1'b1;
    cfg_len_a = 12'd16;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset in flight", 64'(bus_a.rom_valid), 64'd1);
    #1;
    rst_na = 1'b0;
    #1;
    check("async rst rom_valid", 64'(bus_a.rom_valid), 64'd0);
    check("async rst addr1", 64'(bus_a.rom_addr_col1), 64'd0);
    check("async rst addr2", 64'(bus_a.rom_addr_col2), 64'd0);
    check("async rst out_valid", 64'(bus_a.out_valid), 64'd0);
    check("async rst tw_col2", bus_a.tw_col2[1], 64'd0);
    check("async rst busy", 64'(busy_a), 64'd0);
    check("async rst done", 64'(done_a), 64'd0);
    @(negedge clk);
    rst_na = 1'b1;
    @(posedge clk);
    #1;
    run_a(2, 0, 0, "post reset");
    check("overflow A", 64'(ovf_a), 64'd0);

    got_b = 0;
    dones_b = 0;
    start_b   = 1'b1;
    cfg_len_b = 12'd2048;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      bus_b.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus_b.out_valid && bus_b.out_ready) begin
        check_head_b(got_b);
        got_b++;
      end
      if (done_b) dones_b++;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      if (dones_b > 0) break;
    end
    repeat (3) begin
      @(negedge clk);
      if (done_b) dones_b++;
    end
    check("rand entries", 64'(got_b), 64'd2048);
    check("rand done pulses", 64'(dones_b), 64'd1);
    check("rand issues", 64'(iss_b), 64'd2048);
    check("rand issue addresses", 64'(addr_err_b), 64'd0);
    check("rand last addr2", 64'(last_a2_b), 64'd0);
    check("overflow B", 64'(ovf_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
